// File: rtl/win_tile_if.sv
// Sample-stream in / tile-bus out bundle between a sample source and win_tile_gen.
// The master side is the source and tile consumer; the slave side is the tile generator.
interface win_tile_if #(
    parameter int DW   = 10,
    parameter int TILE = 6
);
    logic [DW-1:0]      din;
    logic               din_valid;
    logic               din_sof;
    logic               din_last;
    logic               din_rdy;
    logic [TILE*DW-1:0] tile;
    logic               tile_valid;
    logic               tile_last;
    logic               drop_err;

    modport master (
        output din, din_valid, din_sof, din_last,
        input  din_rdy, tile, tile_valid, tile_last, drop_err
    );

    modport slave (
        input  din, din_valid, din_sof, din_last,
        output din_rdy, tile, tile_valid, tile_last, drop_err
    );
endinterface

// File: rtl/win_tile_gen.sv
// Cuts a framed serial sample stream into overlapping TILE-sample windows at STRIDE,
// zero-padding the final partial tile and stalling the source while it pads.
module win_tile_gen #(
    parameter int DW     = 10,
    parameter int TILE   = 6,
    parameter int STRIDE = 3
) (
    input  logic      clk,
    input  logic      rst,
    win_tile_if.slave bus
);
    localparam int FW = $clog2(TILE + 1);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WW = TILE * DW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STEADY = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t        r_state;
    logic [FW-1:0] r_fill;
    logic [PW-1:0] r_ph;
    logic [WW-1:0] r_win;
    logic [WW-1:0] r_tile;
    logic          r_tile_valid;
    logic          r_tile_last;
    logic          r_drop;
    logic          r_din_rdy;

    state_t        w_state_nxt;
    logic [FW-1:0] w_fill_nxt;
    logic [PW-1:0] w_ph_nxt;
    logic [WW-1:0] w_win_nxt;
    logic [DW-1:0] w_in;
    logic          w_acc;
    logic          w_shift;
    logic          w_restart;
    logic          w_adv;
    logic          w_is_last;
    logic          w_done;
    logic          w_emit;
    logic          w_last;
    logic          w_drop;

    assign w_acc = bus.din_valid && r_din_rdy;

    // A restart clears the history so the new frame's first tile holds only its own samples.
    assign w_win_nxt = w_restart ? {{(WW - DW){1'b0}}, w_in}
                                 : {r_win[WW-DW-1:0], w_in};

    // Next-state, counter and emission decode.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_ph_nxt    = r_ph;
        w_in        = {DW{1'b0}};
        w_shift     = 1'b0;
        w_restart   = 1'b0;
        w_adv       = 1'b0;
        w_is_last   = 1'b0;
        w_done      = 1'b0;
        w_emit      = 1'b0;
        w_last      = 1'b0;
        w_drop      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (bus.din_sof) begin
                        w_restart = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else begin
                    w_drop = 1'b0;
                end
            end
            ST_FILL, ST_STEADY: begin
                if (w_acc) begin
                    if (bus.din_sof) begin
                        w_restart = 1'b1;
                    end else begin
                        w_adv     = 1'b1;
                        w_in      = bus.din;
                        w_is_last = bus.din_last;
                    end
                end else begin
                    w_adv = 1'b0;
                end
            end
            ST_FLUSH: begin
                w_adv     = 1'b1;
                w_in      = {DW{1'b0}};
                w_is_last = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_restart) begin
            w_shift     = 1'b1;
            w_in        = bus.din;
            w_fill_nxt  = FW'(1);
            w_ph_nxt    = {PW{1'b0}};
            w_state_nxt = bus.din_last ? ST_FLUSH : ST_FILL;
        end else if (w_adv) begin
            // Pads advance the counters exactly like samples, so flush ends on the natural tile boundary.
            w_shift = 1'b1;
            if (r_fill < FW'(TILE)) begin
                w_fill_nxt = r_fill + FW'(1);
                w_done     = (w_fill_nxt == FW'(TILE));
                w_ph_nxt   = {PW{1'b0}};
            end else begin
                w_done   = (r_ph == PW'(STRIDE - 1));
                w_ph_nxt = w_done ? {PW{1'b0}} : r_ph + PW'(1);
            end
            if (w_done) begin
                w_emit      = 1'b1;
                w_last      = w_is_last;
                w_state_nxt = w_is_last ? ST_IDLE : ST_STEADY;
            end else begin
                w_state_nxt = w_is_last ? ST_FLUSH : r_state;
            end
        end else begin
            w_shift = 1'b0;
        end
    end

    // State, window and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fill       <= {FW{1'b0}};
            r_ph         <= {PW{1'b0}};
            r_win        <= {WW{1'b0}};
            r_tile       <= {WW{1'b0}};
            r_tile_valid <= 1'b0;
            r_tile_last  <= 1'b0;
            r_drop       <= 1'b0;
            r_din_rdy    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_fill       <= w_fill_nxt;
            r_ph         <= w_ph_nxt;
            if (w_shift) begin
                r_win <= w_win_nxt;
            end else begin
                r_win <= r_win;
            end
            if (w_emit) begin
                r_tile <= w_win_nxt;
            end else begin
                r_tile <= r_tile;
            end
            r_tile_valid <= w_emit;
            r_tile_last  <= w_emit && w_last;
            r_drop       <= w_drop;
            r_din_rdy    <= (w_state_nxt != ST_FLUSH);
        end
    end

    assign bus.din_rdy    = r_din_rdy;
    assign bus.tile       = r_tile;
    assign bus.tile_valid = r_tile_valid;
    assign bus.tile_last  = r_tile_last;
    assign bus.drop_err   = r_drop;
endmodule
